uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial receiver for the bbcpu UART line. Consumes the 8N1 stream driven on
//  uart_tx_line by top and rebuilds bytes LSB-first. Presents each byte on a
//  one-entry valid/ready output register, with framing-error and overrun flags.
//  Used as the checker front end in top-level benches and for FPGA loopback.
// PARAMETERS
//  WIDTH         8  data bits per frame
//  CLKS_PER_BIT  2  clk cycles per serial bit; must be >= 2
//                   (2 = uart_clk at half the clk rate)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      synchronous reset, active low
//  rx_line     in   1      serial input, idle high, asynchronous to frame timing
//  data_out    out  WIDTH  received byte, stable while data_valid=1
//  data_valid  out  1      byte available in holding register
//  data_ready  in   1      consumer accepts; transfer when valid & ready
//  frame_err   out  1      one-cycle pulse: stop bit sampled low
//  overrun     out  1      sticky: byte completed while holding register full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state=IDLE, data_out=0, data_valid=0,
//   frame_err=0, overrun=0, sync FFs=1, bit/clk counters=0. Reset mid-frame
//   aborts the frame with no output.
//  rx_line passes through a 2-FF synchronizer; all decisions use the synced
//   value rxs (2-cycle input latency).
//  HALF = CLKS_PER_BIT/2 (integer division).
//  FSM (one clk counter, one bit counter of $clog2(WIDTH+1) bits):
//   IDLE:  rxs==0 -> START, clk counter=0.
//   START: after HALF cycles, sample rxs. 0 -> DATA, counters=0.
//          1 -> IDLE (glitch rejected, no flags).
//   DATA:  every CLKS_PER_BIT cycles, sample rxs into shift[bit_cnt]
//          (LSB first). After sample WIDTH-1 -> STOP.
//   STOP:  after CLKS_PER_BIT cycles, sample rxs.
//          1 -> commit the byte, then IDLE.
//          0 -> frame_err=1 for exactly one cycle, discard byte, WAIT_HI.
//   WAIT_HI: stay until rxs==1, then IDLE (a held-low break gives one error).
//  Commit rules, evaluated on the commit cycle:
//   holding empty, or data_ready=1 that cycle -> data_out<=shift,
//    data_valid<=1. Simultaneous accept+commit keeps valid=1, no overrun.
//   holding full and data_ready=0 -> new byte dropped, old data_out kept,
//    overrun<=1. overrun clears only on reset.
//  data_valid rises the cycle after the stop-bit sample. It falls the cycle
//   after valid & ready, unless a commit occurs that same cycle.
//  data_out never changes while data_valid=1 and data_ready=0.
//  Back-to-back frames: IDLE is re-entered right after the stop sample, so a
//   start edge in the next bit period is caught.
// TESTING (CLKS_PER_BIT=4 unless noted; ideal frames, 1 stop bit)
//  1. Reset, then frame 0x01, ready=1 -> one-cycle valid, data_out=0x01,
//     frame_err=0, overrun=0.
//  2. CLKS_PER_BIT=2, ready=1, frames back-to-back: 1,2,3,5,8,13,21,34,55,89,
//     144,233 -> exactly 12 valid pulses, values in that order.
//  3. rx_line low for 1 clk only -> no valid, no frame_err, FSM back in IDLE.
//  4. Frame 0xA5 with stop bit 0, then line high, then frame 0x3C ->
//     frame_err pulses once, no valid for 0xA5; 0x3C received correctly.
//  5. ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Raise
//     ready -> 0x11 accepted, valid drops, overrun remains 1.
//  6. rst_n low during bit 4 of 0xFF, release, send 0x42 -> all outputs 0
//     during reset; next valid shows 0x42 only.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun flags.
module uart_rx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_line,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HI
   } state_t;

   state_t             state_q, state_d;
   logic               rx_meta_q, rx_sync_q;
   logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               ferr_q, ferr_d;
   logic               ovr_q, ovr_d;
   logic               commit;
   logic               rxs;

   assign rxs = rx_sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_line;
         rx_sync_q <= rx_meta_q;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = ovr_q;
      commit    = 1'b0;

      if (valid_q && data_ready) valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d   = S_START;
               clk_cnt_d = '0;
            end
         end
         S_START: begin
            if (clk_cnt_q == CNT_HALF) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rxs ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               // LSB arrives first, so shifting in from the top leaves it at bit 0
               shift_d   = {rxs, shift_q[WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_LAST) state_d = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               if (rxs) begin
                  commit  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HI;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_HI: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A same-cycle accept frees the holding register for the new byte
      if (commit) begin
         if (!valid_q || data_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule
